sprite_compositor: RTL and testbench

Parametrised N-layer sprite compositor for the VGA path, replacing fixed three-sprite rendering with a generic, fully pipelined engine. It takes the scan position from the VGA timing block, generates one ROM address per sprite, resolves priority and transparency, maps colour indices through per-sprite palettes and emits a registered 24-bit pixel. Sprite positions and palettes are written by the ARMv4 core through a single-cycle register write port. Positions are double-buffered and swapped at frame start so a frame never tears.

---
 rtl/sprite_compositor_if.sv | 31 +++
 rtl/sprite_compositor.sv | 180 ++++++++++++++++++
 tb/tb_sprite_compositor.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_compositor_if.sv
// Pixel, register-write, sprite ROM and colour-output signals of the sprite compositor.
// The slave modport is the compositor side. The master modport is the side that drives scan, writes and ROM data.
`timescale 1ns/1ps
interface sprite_compositor_if #(
  parameter int NUM_SPRITES = 5,
  parameter int PIX_W       = 10,
  parameter int ADDR_W      = 12,
  parameter int IDX_W       = 3
);
  logic [PIX_W-1:0]              pixelx;
  logic [PIX_W-1:0]              pixely;
  logic                          pixel_valid;
  logic                          frame_start;
  logic                          wr_en;
  logic [7:0]                    wr_addr;
  logic [31:0]                   wr_data;
  logic [NUM_SPRITES*ADDR_W-1:0] rom_addr;
  logic [NUM_SPRITES*IDX_W-1:0]  rom_data;
  logic [23:0]                   out_color;
  logic                          out_valid;

  modport master (
    output pixelx, pixely, pixel_valid, frame_start, wr_en, wr_addr, wr_data, rom_data,
    input  rom_addr, out_color, out_valid
  );

  modport slave (
    input  pixelx, pixely, pixel_valid, frame_start, wr_en, wr_addr, wr_data, rom_data,
    output rom_addr, out_color, out_valid
  );
endinterface

// File: rtl/sprite_compositor.sv
// N-layer sprite compositor: per-sprite hit test and ROM addressing, priority/transparency
// resolve, palette lookup; sprite positions are double-buffered and swapped at frame start.
`timescale 1ns/1ps
module sprite_compositor #(
  parameter int          NUM_SPRITES = 5,
  parameter int          PIX_W       = 10,
  parameter int          POS_W       = 11,
  parameter int          LOG_W       = 6,
  parameter int          LOG_H       = 6,
  parameter int          IDX_W       = 3,
  parameter int          ROM_LAT     = 1,
  parameter logic [23:0] BG_RESET    = 24'h03FCDB
) (
  input  logic               clk,
  input  logic               rst,
  sprite_compositor_if.slave bus
);
  localparam int ADDR_W  = LOG_W + LOG_H;
  localparam int SID_W   = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
  localparam int PAL_AW  = SID_W + IDX_W;
  localparam int NUM_PAL = NUM_SPRITES * (1 << IDX_W);
  localparam int D_W     = POS_W + 1;

  logic [POS_W-1:0]              sh_x_q  [NUM_SPRITES];
  logic [POS_W-1:0]              sh_y_q  [NUM_SPRITES];
  logic [POS_W-1:0]              act_x_q [NUM_SPRITES];
  logic [POS_W-1:0]              act_y_q [NUM_SPRITES];
  logic [NUM_SPRITES-1:0]        sh_en_q;
  logic [NUM_SPRITES-1:0]        act_en_q;
  logic [23:0]                   bg_q;
  logic [23:0]                   pal_q   [1 << PAL_AW];

  logic                          pal_wr;
  logic [PAL_AW-1:0]             pal_idx;
  logic                          unused_wr_bits;

  logic [D_W-1:0]                dx [NUM_SPRITES];
  logic [D_W-1:0]                dy [NUM_SPRITES];
  logic [NUM_SPRITES-1:0]        hit;
  logic [NUM_SPRITES*ADDR_W-1:0] addr;

  logic [NUM_SPRITES*ADDR_W-1:0] rom_addr_q;
  logic [NUM_SPRITES-1:0]        hit_q [ROM_LAT+1];
  logic [ROM_LAT:0]              vld_q;

  logic [NUM_SPRITES-1:0]        vis;
  logic [SID_W-1:0]              win_id;
  logic [IDX_W-1:0]              win_idx;
  logic                          win_none;
  logic [SID_W-1:0]              win_id_q;
  logic [IDX_W-1:0]              win_idx_q;
  logic                          bg_sel_q;
  logic                          vld_b_q;

  logic [23:0]                   color_d;
  logic [23:0]                   out_color_q;
  logic                          out_valid_q;

  // Palette write decode; entries past the last sprite are never written.
  assign pal_wr  = bus.wr_en && bus.wr_addr[7] && ({1'b0, bus.wr_addr[6:0]} < 8'(NUM_PAL));
  assign pal_idx = bus.wr_addr[PAL_AW-1:0];
  assign unused_wr_bits = ^bus.wr_data[30:27];

  // Shadow/active sprite registers, background colour and palette.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < NUM_SPRITES; s++) begin
        sh_x_q[s]  <= '0;
        sh_y_q[s]  <= '0;
        act_x_q[s] <= '0;
        act_y_q[s] <= '0;
      end
      sh_en_q  <= '0;
      act_en_q <= '0;
      bg_q     <= BG_RESET;
      for (int p = 0; p < (1 << PAL_AW); p++) begin
        pal_q[p] <= '0;
      end
    end else begin
      if (bus.frame_start) begin
        for (int s = 0; s < NUM_SPRITES; s++) begin
          act_x_q[s] <= sh_x_q[s];
          act_y_q[s] <= sh_y_q[s];
        end
        act_en_q <= sh_en_q;
      end
      for (int s = 0; s < NUM_SPRITES; s++) begin
        if (bus.wr_en && (bus.wr_addr == 8'(s))) begin
          sh_x_q[s]  <= bus.wr_data[POS_W-1:0];
          sh_y_q[s]  <= bus.wr_data[16 +: POS_W];
          sh_en_q[s] <= bus.wr_data[31];
        end
      end
      if (bus.wr_en && (bus.wr_addr == 8'h20)) begin
        bg_q <= bus.wr_data[23:0];
      end
      if (pal_wr) begin
        pal_q[pal_idx] <= bus.wr_data[23:0];
      end
    end
  end

  // Hit test and ROM address per sprite; negative positions clip at left/top.
  always_comb begin
    hit  = '0;
    addr = '0;
    for (int s = 0; s < NUM_SPRITES; s++) begin
      dx[s] = {{(D_W-PIX_W){1'b0}}, bus.pixelx} - {act_x_q[s][POS_W-1], act_x_q[s]};
      dy[s] = {{(D_W-PIX_W){1'b0}}, bus.pixely} - {act_y_q[s][POS_W-1], act_y_q[s]};
      hit[s] = act_en_q[s] && (dx[s][D_W-1:LOG_W] == '0) && (dy[s][D_W-1:LOG_H] == '0);
      addr[s*ADDR_W +: ADDR_W] = hit[s] ? {dy[s][LOG_H-1:0], dx[s][LOG_W-1:0]} : '0;
    end
  end

  // Stage A, plus hit/valid delay lines aligning with ROM data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_addr_q <= '0;
      vld_q      <= '0;
      for (int k = 0; k <= ROM_LAT; k++) begin
        hit_q[k] <= '0;
      end
    end else begin
      rom_addr_q <= addr;
      hit_q[0]   <= hit;
      vld_q      <= {vld_q[ROM_LAT-1:0], bus.pixel_valid};
      for (int k = 1; k <= ROM_LAT; k++) begin
        hit_q[k] <= hit_q[k-1];
      end
    end
  end

  // Lowest-numbered visible sprite wins; index 0 is transparent.
  always_comb begin
    win_id   = '0;
    win_idx  = '0;
    win_none = 1'b1;
    for (int s = NUM_SPRITES - 1; s >= 0; s--) begin
      vis[s]   = hit_q[ROM_LAT][s] && (bus.rom_data[s*IDX_W +: IDX_W] != '0);
      win_id   = vis[s] ? SID_W'(s) : win_id;
      win_idx  = vis[s] ? bus.rom_data[s*IDX_W +: IDX_W] : win_idx;
      win_none = vis[s] ? 1'b0 : win_none;
    end
  end

  // Colour select for Stage C; blanked when the pixel is not valid.
  always_comb begin
    color_d = 24'h000000;
    if (!vld_b_q) begin
      color_d = 24'h000000;
    end else if (bg_sel_q) begin
      color_d = bg_q;
    end else begin
      color_d = pal_q[{win_id_q, win_idx_q}];
    end
  end

  // Stage B (winner) and Stage C (output colour) registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_id_q    <= '0;
      win_idx_q   <= '0;
      bg_sel_q    <= 1'b0;
      vld_b_q     <= 1'b0;
      out_color_q <= 24'h000000;
      out_valid_q <= 1'b0;
    end else begin
      win_id_q    <= win_id;
      win_idx_q   <= win_idx;
      bg_sel_q    <= win_none;
      vld_b_q     <= vld_q[ROM_LAT];
      out_color_q <= color_d;
      out_valid_q <= vld_b_q;
    end
  end

  assign bus.rom_addr  = rom_addr_q;
  assign bus.out_color = out_color_q;
  assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_sprite_compositor.sv
// Scoreboard bench for sprite_compositor: directed pixels push expected colour/ROM address,
// a negedge monitor pops and compares against what the design presents.
`timescale 1ns/1ps
module tb_sprite_compositor;
  localparam int          NS  = 5;
  localparam int          IW  = 3;
  localparam int          AW  = 12;
  localparam logic [23:0] BG0 = 24'h03FCDB;
  localparam logic [23:0] BG1 = 24'h123456;
  localparam logic [23:0] YEL = 24'hFFFF00;
  localparam logic [23:0] C25 = 24'h112233;
  localparam logic [23:0] C03 = 24'h445566;
  localparam logic [23:0] C11 = 24'hABCDEF;

  typedef struct { int due; logic [23:0] color; } cexp_t;
  typedef struct { int due; int spr; logic [AW-1:0] addr; } rexp_t;

  logic       clk;
  logic       rst;
  int         cyc      = 0;
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [IW-1:0] rom_val [NS];
  cexp_t      cq [$];
  rexp_t      rq [$];
  cexp_t      ce;
  rexp_t      re;

  sprite_compositor_if #(.NUM_SPRITES(NS), .PIX_W(10), .ADDR_W(AW), .IDX_W(IW)) bus ();

  sprite_compositor #(.NUM_SPRITES(NS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Sprite ROM model with one cycle of read latency.
  always @(posedge clk) begin
    for (int s = 0; s < NS; s++) begin
      bus.rom_data[s*IW +: IW] <= rom_val[s];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] spr_word(input logic en, input logic [10:0] x, input logic [10:0] y);
    return {en, 4'd0, y, 5'd0, x};
  endfunction

  task automatic drive(input logic v, input int x, input int y, input logic f,
                       input logic we, input logic [7:0] wa, input logic [31:0] wd);
    bus.pixel_valid = v;
    bus.pixelx      = 10'(x);
    bus.pixely      = 10'(y);
    bus.frame_start = f;
    bus.wr_en       = we;
    bus.wr_addr     = wa;
    bus.wr_data     = wd;
    @(posedge clk);
    #1;
    bus.pixel_valid = 1'b0;
    bus.frame_start = 1'b0;
    bus.wr_en       = 1'b0;
  endtask

  task automatic pix(input int x, input int y, input logic [23:0] c);
    cq.push_back('{due: cyc + 4, color: c});
    drive(1'b1, x, y, 1'b0, 1'b0, 8'h00, 32'h0);
  endtask

  task automatic pixr(input int x, input int y, input logic [23:0] c, input int s, input logic [AW-1:0] a);
    rq.push_back('{due: cyc + 1, spr: s, addr: a});
    pix(x, y, c);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    drive(1'b0, 0, 0, 1'b0, 1'b1, a, d);
  endtask

  task automatic fs();
    drive(1'b0, 0, 0, 1'b1, 1'b0, 8'h00, 32'h0);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 0, 0, 1'b0, 1'b0, 8'h00, 32'h0);
  endtask

  // Monitor: compares every cycle against the scoreboard queues.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_hold_valid", 64'(bus.out_valid), 64'h0);
      chk("rst_hold_color", 64'(bus.out_color), 64'h0);
    end else begin
      while (rq.size() > 0 && rq[0].due == cyc) begin
        re = rq.pop_front();
        chk($sformatf("rom_addr_s%0d", re.spr), 64'(bus.rom_addr[re.spr*AW +: AW]), 64'(re.addr));
      end
      if (cq.size() > 0 && cq[0].due == cyc) begin
        ce = cq.pop_front();
        chk("out_valid", 64'(bus.out_valid), 64'h1);
        chk("out_color", 64'(bus.out_color), 64'(ce.color));
      end else begin
        chk("out_valid_idle", 64'(bus.out_valid), 64'h0);
        if (!bus.out_valid) chk("blank_color", 64'(bus.out_color), 64'h0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int s = 0; s < NS; s++) rom_val[s] = '0;
    bus.pixelx = '0; bus.pixely = '0; bus.pixel_valid = 1'b0; bus.frame_start = 1'b0;
    bus.wr_en = 1'b0; bus.wr_addr = 8'h00; bus.wr_data = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", 64'(bus.out_valid), 64'h0);
    chk("reset_out_color", 64'(bus.out_color), 64'h0);
    chk("reset_rom_addr", 64'(bus.rom_addr), 64'h0);
    rst = 1'b0;
    idle(1);

    // No sprite enabled: background everywhere, all ROM addresses zero.
    pixr(10, 10, BG0, 0, 12'h000);
    pixr(20, 20, BG0, 4, 12'h000);
    pix(30, 30, BG0);
    pix(639, 479, BG0);
    idle(5);

    // Sprite 0 at (100,50), palette[0][1] yellow, ROM index 1.
    wr(8'h81, 32'h00FFFF00);
    wr(8'h00, spr_word(1'b1, 11'd100, 11'd50));
    rom_val[0] = 3'd1;
    fs();
    pixr(100, 50, YEL, 0, 12'h000);
    pixr(163, 113, YEL, 0, 12'hFFF);
    pixr(164, 50, BG0, 0, 12'h000);
    pixr(99, 50, BG0, 0, 12'h000);
    pix(130, 80, YEL);
    idle(5);

    // Overlap of sprites 0 and 2: transparency then priority.
    wr(8'h02, spr_word(1'b1, 11'd100, 11'd50));
    wr(8'h95, 32'h00112233);
    wr(8'h83, 32'h00445566);
    rom_val[0] = 3'd0;
    rom_val[2] = 3'd5;
    fs();
    idle(1);
    pixr(110, 60, C25, 2, 12'h28A);
    idle(5);
    rom_val[0] = 3'd3;
    idle(1);
    pixr(110, 60, C03, 0, 12'h28A);
    pix(200, 60, BG0);
    idle(5);

    // Sprite 1 at x = -10: left-edge clipping.
    wr(8'h00, spr_word(1'b0, 11'd100, 11'd50));
    wr(8'h02, spr_word(1'b0, 11'd100, 11'd50));
    wr(8'h01, spr_word(1'b1, 11'h7F6, 11'd0));
    wr(8'h89, 32'h00ABCDEF);
    rom_val[0] = 3'd0;
    rom_val[1] = 3'd1;
    rom_val[2] = 3'd0;
    fs();
    pixr(0, 0, C11, 1, 12'd10);
    pixr(53, 0, C11, 1, 12'd63);
    pixr(54, 0, BG0, 1, 12'h000);
    pixr(10, 63, C11, 1, 12'hFD4);
    pix(10, 64, BG0);
    idle(5);

    // Shadow buffering, including a write coincident with frame_start.
    wr(8'h01, spr_word(1'b1, 11'd200, 11'd0));
    pix(0, 0, C11);
    fs();
    pix(0, 0, BG0);
    pix(200, 0, C11);
    drive(1'b0, 0, 0, 1'b1, 1'b1, 8'h01, spr_word(1'b1, 11'd300, 11'd0));
    pix(200, 0, C11);
    pix(300, 0, BG0);
    fs();
    pix(300, 0, C11);
    pix(200, 0, BG0);
    idle(5);

    // Background write, ignored writes, and a 3-cycle pixel_valid gap.
    wr(8'h20, 32'h00123456);
    wr(8'h05, spr_word(1'b1, 11'd500, 11'd400));
    wr(8'h40, 32'h00FF0000);
    fs();
    pix(500, 400, BG1);
    pix(501, 400, BG1);
    idle(3);
    pix(502, 400, BG1);
    pix(300, 0, C11);
    idle(6);

    // Reset mid-line: pipeline flushes, registers return to reset values.
    for (int i = 0; i < 5; i++) pix(500 + i, 400, BG1);
    rst = 1'b1;
    cq.delete();
    rq.delete();
    #1;
    chk("midrst_out_valid", 64'(bus.out_valid), 64'h0);
    chk("midrst_out_color", 64'(bus.out_color), 64'h0);
    chk("midrst_rom_addr", 64'(bus.rom_addr), 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    pixr(300, 0, BG0, 1, 12'h000);
    idle(5);
    wr(8'h01, spr_word(1'b1, 11'd300, 11'd0));
    fs();
    pixr(300, 0, 24'h000000, 1, 12'h000);
    pix(0, 0, BG0);
    idle(8);

    chk("color_queue_drained", 64'(cq.size()), 64'h0);
    chk("rom_queue_drained", 64'(rq.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
